// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Values and types shared by the fetch stage and its skid
//               buffer: reset PC, sequential PC step, bubble instruction
//               word, buffer depth and the {pc, instr} buffer entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
    localparam int          BUF_DEPTH = 2;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buffer
// Description : Two-entry FIFO of fetch_entry_t. Slot 0 is always the head.
//               Push and pop in the same cycle are supported at count 1 and
//               count 2; clear empties the FIFO and wins over push/pop.
// Ports       : clk        - core clock, rising edge
//               rst        - asynchronous, active-low reset
//               push       - write push_entry at the tail
//               pop        - discard the head entry
//               clear      - drop every entry
//               push_entry - entry written on push
//               head       - oldest entry (meaningful when count != 0)
//               count      - number of valid entries, 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buffer (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  core_pkg::fetch_entry_t push_entry,
    output core_pkg::fetch_entry_t head,
    output logic [1:0]             count
);
    import core_pkg::*;

    fetch_entry_t r_slot0;
    fetch_entry_t r_slot1;
    logic [1:0]   r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 2'd0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else if (clear) begin
            r_count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    // A push at count 2 is prevented by the fetch credit
                    // check; it is dropped here rather than corrupting slots.
                    if (r_count == 2'd0) begin
                        r_slot0 <= push_entry;
                        r_count <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_slot1 <= push_entry;
                        r_count <= 2'd2;
                    end
                end
                2'b01: begin
                    if (r_count != 2'd0) begin
                        r_slot0 <= r_slot1;
                        r_count <= r_count - 2'd1;
                    end
                end
                2'b11: begin
                    // Count is unchanged except from empty, where the pop
                    // has nothing to remove and only the push takes effect.
                    if (r_count == 2'd2) begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= push_entry;
                    end else if (r_count == 2'd1) begin
                        r_slot0 <= push_entry;
                    end else begin
                        r_slot0 <= push_entry;
                        r_count <= 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head  = r_slot0;
    assign count = r_count;

endmodule : fetch_skid_buffer
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Owns the PC, issues reads to a
//               synchronous instruction memory (data one cycle after the
//               request), and drives the IF/ID register. Responses that
//               cannot enter IF/ID because of a stall are parked in a
//               two-entry skid buffer; issue is throttled so the buffer
//               plus the in-flight read never exceed its depth. A redirect
//               flushes the buffer and the in-flight read.
// Ports       : clk            - core clock, rising edge
//               rst            - asynchronous, active-low reset
//               stall          - downstream cannot accept; hold IF/ID
//               redirect_valid - taken branch/jump this cycle
//               redirect_pc    - target PC, valid with redirect_valid
//               imem_req       - instruction memory read request
//               imem_addr      - read address (current PC)
//               imem_rdata     - read data, valid the cycle after imem_req
//               IF_ID_valid    - IF/ID holds a real instruction
//               IF_ID_pc       - PC of the IF/ID instruction
//               IF_ID_instr    - IF/ID instruction word
//               fetch_pc       - current PC register (trace)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = core_pkg::RESET_PC,
    parameter logic [31:0] PC_STEP   = core_pkg::PC_STEP,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR,
    parameter int          BUF_DEPTH = core_pkg::BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        IF_ID_valid,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] fetch_pc
);
    import core_pkg::*;

    // Only a depth of two is supported by the skid buffer.
    localparam logic [1:0] c_depth = 2'(BUF_DEPTH);

    logic [31:0]  r_pc;
    logic         r_inflight;
    logic [31:0]  r_inflight_pc;
    logic         r_if_valid;
    logic [31:0]  r_if_pc;
    logic [31:0]  r_if_instr;

    logic [1:0]   w_count;
    logic [1:0]   w_occupancy;
    logic         w_issue;
    logic         w_resp;
    logic         w_bypass;
    logic         w_push;
    logic         w_pop;
    fetch_entry_t w_head;
    fetch_entry_t w_resp_entry;

    // Credit: every outstanding read must have a guaranteed buffer slot,
    // so buffered entries plus the in-flight read stay within the depth.
    // Max occupancy is 2 + 1 = 3, which still fits in two bits.
    assign w_occupancy = w_count + {1'b0, r_inflight};
    assign w_issue     = rst && !redirect_valid && (w_occupancy < c_depth);

    // A response arriving during a redirect belongs to the flushed path.
    assign w_resp       = r_inflight && !redirect_valid;
    assign w_resp_entry = '{pc: r_inflight_pc, instr: imem_rdata};

    // The response may skip the buffer only when nothing older is waiting
    // and IF/ID is free to take it this cycle.
    assign w_bypass = w_resp && !stall && (w_count == 2'd0);
    assign w_push   = w_resp && !w_bypass;
    assign w_pop    = !redirect_valid && !stall && (w_count != 2'd0);

    fetch_skid_buffer u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .pop        (w_pop),
        .clear      (redirect_valid),
        .push_entry (w_resp_entry),
        .head       (w_head),
        .count      (w_count)
    );

    // PC and in-flight tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
        end else begin
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + PC_STEP;
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
            end
        end
    end

    // IF/ID register: redirect beats stall; the buffer head is older than
    // any response landing this cycle, so it is served first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'h0000_0000;
            r_if_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
        end else if (!stall) begin
            if (w_count != 2'd0) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= w_head.pc;
                r_if_instr <= w_head.instr;
            end else if (w_bypass) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_inflight_pc;
                r_if_instr <= imem_rdata;
            end else begin
                r_if_valid <= 1'b0;
                r_if_instr <= NOP_INSTR;
            end
        end
    end

    assign imem_req    = w_issue;
    assign imem_addr   = r_pc;
    assign fetch_pc    = r_pc;
    assign IF_ID_valid = r_if_valid;
    assign IF_ID_pc    = r_if_pc;
    assign IF_ID_instr = r_if_instr;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. Directed scenarios plus
//               a randomized stall/redirect run checked against a
//               program-order model of the IF/ID stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        IF_ID_valid;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic [31:0] fetch_pc;

    int n_checks = 0;
    int n_fails  = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .IF_ID_valid    (IF_ID_valid),
        .IF_ID_pc       (IF_ID_pc),
        .IF_ID_instr    (IF_ID_instr),
        .fetch_pc       (fetch_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Synchronous instruction memory; garbage when not requested.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    // The credit scheme must never push into a full buffer.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            n_checks++;
            assert (!(dut.u_skid.push && !dut.u_skid.pop && dut.u_skid.count == 2'd2))
            else begin
                n_fails++;
                $display("FAIL skid_push_on_full: count=%0d push=%b pop=%b, required no push at count 2",
                         dut.u_skid.count, dut.u_skid.push, dut.u_skid.pop);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after reset release.
    task automatic do_reset();
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({IF_ID_valid, IF_ID_pc, IF_ID_instr, fetch_pc, imem_req} !== {1'b0, 32'h0, c_nop, 32'h0, 1'b0}) begin
            n_fails++;
            $display("FAIL reset_async: got v=%b pc=%h ins=%h fpc=%h req=%b, want 0/0/%h/0/0",
                     IF_ID_valid, IF_ID_pc, IF_ID_instr, fetch_pc, imem_req, c_nop);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({IF_ID_valid, IF_ID_instr, imem_req} !== {1'b0, c_nop, 1'b0}) begin
            n_fails++;
            $display("FAIL reset_held: got v=%b ins=%h req=%b, want 0/%h/0", IF_ID_valid, IF_ID_instr, imem_req, c_nop);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_fails++;
            $display("FAIL first_issue: got req=%b addr=%h, want 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        tick();
        n_checks++;
        if (IF_ID_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL stream_edge1: got valid=%b want 0", IF_ID_valid);
        end
        for (int k = 0; k < 3; k++) begin
            logic [31:0] p;
            p = 32'(4 * k);
            tick();
            n_checks++;
            if ({IF_ID_valid, IF_ID_pc, IF_ID_instr, imem_req} !== {1'b1, p, mem_word(p), 1'b1}) begin
                n_fails++;
                $display("FAIL stream_pc: got v=%b pc=%h ins=%h req=%b, want 1/%h/%h/1",
                         IF_ID_valid, IF_ID_pc, IF_ID_instr, imem_req, p, mem_word(p));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_req;
        exp_req = 32'b0001;  // per stall cycle: req before edge 1,2,3 then after release
        stall = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (imem_req !== exp_req[k]) begin
                n_fails++;
                $display("FAIL stall_req_%0d: got %b want %b", k, imem_req, exp_req[k]);
            end
            tick();
            n_checks++;
            if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {1'b1, 32'h8, mem_word(32'h8)}) begin
                n_fails++;
                $display("FAIL stall_hold_%0d: got v=%b pc=%h ins=%h, want 1/00000008/%h",
                         k, IF_ID_valid, IF_ID_pc, IF_ID_instr, mem_word(32'h8));
            end
        end
        n_checks++;
        if (dut.u_skid.count !== 2'd2) begin
            n_fails++;
            $display("FAIL stall_count: got %0d want 2", dut.u_skid.count);
        end
        stall = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fails++;
            $display("FAIL release_req: got %b want 0", imem_req);
        end
        for (int k = 3; k < 6; k++) begin
            logic [31:0] p;
            p = 32'(4 * k);
            tick();
            n_checks++;
            if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {1'b1, p, mem_word(p)}) begin
                n_fails++;
                $display("FAIL drain_pc: got v=%b pc=%h ins=%h, want 1/%h/%h",
                         IF_ID_valid, IF_ID_pc, IF_ID_instr, p, mem_word(p));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (6) tick();
        n_checks++;
        if (IF_ID_pc !== 32'h10) begin
            n_fails++;
            $display("FAIL redir_setup: got pc=%h want 00000010", IF_ID_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fails++;
            $display("FAIL redir_req: got %b want 0", imem_req);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if ({IF_ID_valid, IF_ID_instr, imem_req, imem_addr} !== {1'b0, c_nop, 1'b1, 32'h100}) begin
            n_fails++;
            $display("FAIL redir_edge1: got v=%b ins=%h req=%b addr=%h, want 0/%h/1/00000100",
                     IF_ID_valid, IF_ID_instr, imem_req, imem_addr, c_nop);
        end
        tick();
        n_checks++;
        if (IF_ID_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL redir_edge2: got valid=%b pc=%h want valid 0", IF_ID_valid, IF_ID_pc);
        end
        for (int k = 0; k < 2; k++) begin
            logic [31:0] p;
            p = 32'h100 + 32'(4 * k);
            tick();
            n_checks++;
            if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {1'b1, p, mem_word(p)}) begin
                n_fails++;
                $display("FAIL redir_target: got v=%b pc=%h ins=%h, want 1/%h/%h",
                         IF_ID_valid, IF_ID_pc, IF_ID_instr, p, mem_word(p));
            end
        end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1;
        tick();
        tick();
        n_checks++;
        if (dut.u_skid.count !== 2'd2) begin
            n_fails++;
            $display("FAIL rs_setup_count: got %0d want 2", dut.u_skid.count);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        #1;
        n_checks++;
        if ({dut.u_skid.count, IF_ID_valid, IF_ID_instr, imem_req, imem_addr} !== {2'd0, 1'b0, c_nop, 1'b1, 32'h200}) begin
            n_fails++;
            $display("FAIL rs_flush: got cnt=%0d v=%b ins=%h req=%b addr=%h, want 0/0/%h/1/00000200",
                     dut.u_skid.count, IF_ID_valid, IF_ID_instr, imem_req, imem_addr, c_nop);
        end
        tick();
        tick();
        n_checks++;
        if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {1'b1, 32'h200, mem_word(32'h200)}) begin
            n_fails++;
            $display("FAIL rs_target: got v=%b pc=%h ins=%h, want 1/00000200/%h",
                     IF_ID_valid, IF_ID_pc, IF_ID_instr, mem_word(32'h200));
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fails++;
            $display("FAIL wrap_issue: got req=%b addr=%h want 1/fffffffc", imem_req, imem_addr);
        end
        tick();
        n_checks++;
        if ({fetch_pc, imem_addr} !== {32'h0, 32'h0}) begin
            n_fails++;
            $display("FAIL wrap_pc: got fpc=%h addr=%h want 00000000", fetch_pc, imem_addr);
        end
        tick();
        n_checks++;
        if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)}) begin
            n_fails++;
            $display("FAIL wrap_last: got v=%b pc=%h ins=%h want 1/fffffffc/%h",
                     IF_ID_valid, IF_ID_pc, IF_ID_instr, mem_word(32'hFFFF_FFFC));
        end
        tick();
        n_checks++;
        if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {1'b1, 32'h0, mem_word(32'h0)}) begin
            n_fails++;
            $display("FAIL wrap_next: got v=%b pc=%h ins=%h want 1/00000000/%h",
                     IF_ID_valid, IF_ID_pc, IF_ID_instr, mem_word(32'h0));
        end
    endtask

    task automatic test_reset_mid_stall();
        stall = 1'b1;
        tick();
        tick();
        n_checks++;
        if (dut.u_skid.count !== 2'd2) begin
            n_fails++;
            $display("FAIL rms_setup_count: got %0d want 2", dut.u_skid.count);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({IF_ID_valid, IF_ID_pc, IF_ID_instr, fetch_pc, imem_req, dut.u_skid.count}
                !== {1'b0, 32'h0, c_nop, 32'h0, 1'b0, 2'd0}) begin
            n_fails++;
            $display("FAIL rms_async: got v=%b pc=%h ins=%h fpc=%h req=%b cnt=%0d, want reset values",
                     IF_ID_valid, IF_ID_pc, IF_ID_instr, fetch_pc, imem_req, dut.u_skid.count);
        end
        stall = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_fails++;
            $display("FAIL rms_restart: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
        end
        tick();
        n_checks++;
        if (IF_ID_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL rms_edge1: got valid=%b pc=%h want valid 0", IF_ID_valid, IF_ID_pc);
        end
        for (int k = 0; k < 2; k++) begin
            logic [31:0] p;
            p = 32'(4 * k);
            tick();
            n_checks++;
            if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {1'b1, p, mem_word(p)}) begin
                n_fails++;
                $display("FAIL rms_stream: got v=%b pc=%h ins=%h, want 1/%h/%h",
                         IF_ID_valid, IF_ID_pc, IF_ID_instr, p, mem_word(p));
            end
        end
    endtask

    // Program-order model: each newly delivered instruction must be the next
    // PC after the previous one (or the redirect target), carry mem[pc], and
    // IF/ID must hold under stall and clear on redirect. Outside of redirect
    // or reset recovery, at most one bubble may separate deliveries.
    task automatic test_random();
        logic [31:0] exp_pc, m_pc, m_instr, t;
        logic        m_valid, s, r;
        int          run;
        do_reset();
        exp_pc = 32'h0; m_pc = 32'h0; m_instr = c_nop; m_valid = 1'b0; run = 0;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 15) == 0);
            t = $urandom & 32'hFFFF_FFFC;
            stall = s; redirect_valid = r; redirect_pc = t;
            #1;
            n_checks++;
            if (imem_addr !== fetch_pc || (r && imem_req !== 1'b0)) begin
                n_fails++;
                $display("FAIL rnd_issue[%0d]: got addr=%h fpc=%h req=%b redirect=%b", i, imem_addr, fetch_pc, imem_req, r);
            end
            tick();
            if (r) begin
                m_valid = 1'b0; m_instr = c_nop; exp_pc = t; run = 0;
            end else if (!s) begin
                if (IF_ID_valid === 1'b1) begin
                    m_valid = 1'b1; m_pc = exp_pc; m_instr = mem_word(exp_pc);
                    exp_pc = exp_pc + 32'd4; run = 0;
                end else begin
                    m_valid = 1'b0; m_instr = c_nop; run++;
                    n_checks++;
                    if (run > 1) begin
                        n_fails++;
                        $display("FAIL rnd_bubbles[%0d]: got %0d consecutive bubbles want at most 1", i, run);
                    end
                end
            end
            n_checks++;
            if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {m_valid, m_pc, m_instr}) begin
                n_fails++;
                $display("FAIL rnd_ifid[%0d]: got v=%b pc=%h ins=%h want v=%b pc=%h ins=%h",
                         i, IF_ID_valid, IF_ID_pc, IF_ID_instr, m_valid, m_pc, m_instr);
            end
        end
        stall = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
